// File: rtl/udp_rx_frame_packer.sv
// udp_rx_frame_packer
// Packs the byte-serial UDP receive stream from eth_udp_test into one wide frame
// register and hands it to user logic over a valid/ready handshake. A packet that
// arrives while the previous frame is still held is dropped and counted.
module udp_rx_frame_packer #(
    parameter int unsigned UDP_LENGTH = 960,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    rgmii_clk,
    input  logic                    rstn,
    input  logic                    udp_rec_data_valid,
    input  logic [7:0]              udp_rec_rdata,
    input  logic [15:0]             udp_rec_data_length,
    output logic                    rx_frame_valid,
    input  logic                    rx_frame_ready,
    output logic [UDP_LENGTH*8-1:0] rx_frame_data,
    output logic [CNT_W-1:0]        rx_frame_length,
    output logic                    rx_frame_trunc,
    output logic                    rx_frame_len_err,
    output logic [CNT_W-1:0]        rx_drop_cnt
);

    localparam int unsigned IDX_W = $clog2(UDP_LENGTH * 8);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(UDP_LENGTH);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDrop
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  byte_cnt_q;
    logic [CNT_W-1:0]  len_q;
    logic              accept;
    logic [IDX_W-1:0]  wr_base;

    assign accept = rx_frame_valid & rx_frame_ready;

    // Bit offset of the slot the next byte lands in; slot 0 sits at the MSB end.
    always_comb begin
        wr_base = '0;
        if (byte_cnt_q < LEN_MAX) begin
            wr_base = IDX_W'((UDP_LENGTH - 1 - 32'(byte_cnt_q)) * 8);
        end
    end

    // Receive FSM with registered frame outputs, byte counter and drop counter.
    always_ff @(posedge rgmii_clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= StIdle;
            byte_cnt_q       <= '0;
            len_q            <= '0;
            rx_frame_valid   <= 1'b0;
            rx_frame_data    <= '0;
            rx_frame_length  <= '0;
            rx_frame_trunc   <= 1'b0;
            rx_frame_len_err <= 1'b0;
            rx_drop_cnt      <= '0;
        end else begin
            // A handshake is honoured in every state; COLLECT never holds a frame.
            if (accept) begin
                rx_frame_valid <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (udp_rec_data_valid) begin
                        if (!rx_frame_valid || accept) begin
                            state_q          <= StCollect;
                            rx_frame_data    <= {udp_rec_rdata, {((UDP_LENGTH - 1) * 8){1'b0}}};
                            byte_cnt_q       <= CNT_W'(1);
                            len_q            <= CNT_W'(udp_rec_data_length);
                            rx_frame_trunc   <= 1'b0;
                            rx_frame_len_err <= 1'b0;
                        end else begin
                            state_q <= StDrop;
                        end
                    end
                end

                StCollect: begin
                    if (udp_rec_data_valid) begin
                        if (byte_cnt_q < LEN_MAX) begin
                            rx_frame_data[wr_base +: 8] <= udp_rec_rdata;
                        end else begin
                            rx_frame_trunc <= 1'b0 | 1'b1;
                        end
                        if (byte_cnt_q != '1) begin
                            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_q          <= StIdle;
                        rx_frame_valid   <= 1'b1;
                        rx_frame_length  <= (byte_cnt_q > LEN_MAX) ? LEN_MAX : byte_cnt_q;
                        rx_frame_len_err <= (byte_cnt_q != len_q);
                    end
                end

                StDrop: begin
                    // Held frame stays untouched; only the drop counter moves.
                    if (!udp_rec_data_valid) begin
                        state_q <= StIdle;
                        if (rx_drop_cnt != '1) begin
                            rx_drop_cnt <= rx_drop_cnt + CNT_W'(1);
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rx_frame_packer.sv
// Directed bench for udp_rx_frame_packer with an 8-byte frame register.
module tb_udp_rx_frame_packer;

    localparam int unsigned UDP_LENGTH = 8;
    localparam int unsigned CNT_W      = 16;

    logic                    rgmii_clk;
    logic                    rstn;
    logic                    udp_rec_data_valid;
    logic [7:0]              udp_rec_rdata;
    logic [15:0]             udp_rec_data_length;
    logic                    rx_frame_valid;
    logic                    rx_frame_ready;
    logic [UDP_LENGTH*8-1:0] rx_frame_data;
    logic [CNT_W-1:0]        rx_frame_length;
    logic                    rx_frame_trunc;
    logic                    rx_frame_len_err;
    logic [CNT_W-1:0]        rx_drop_cnt;

    int checks;
    int errors;
    logic [7:0] pkt [16];

    udp_rx_frame_packer #(
        .UDP_LENGTH (UDP_LENGTH),
        .CNT_W      (CNT_W)
    ) dut (
        .rgmii_clk           (rgmii_clk),
        .rstn                (rstn),
        .udp_rec_data_valid  (udp_rec_data_valid),
        .udp_rec_rdata       (udp_rec_rdata),
        .udp_rec_data_length (udp_rec_data_length),
        .rx_frame_valid      (rx_frame_valid),
        .rx_frame_ready      (rx_frame_ready),
        .rx_frame_data       (rx_frame_data),
        .rx_frame_length     (rx_frame_length),
        .rx_frame_trunc      (rx_frame_trunc),
        .rx_frame_len_err    (rx_frame_len_err),
        .rx_drop_cnt         (rx_drop_cnt)
    );

    initial rgmii_clk = 1'b0;
    always #5 rgmii_clk = ~rgmii_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set beforehand are sampled at this edge.
    task automatic step();
        @(posedge rgmii_clk);
        #1;
    endtask

    // Drive n bytes from pkt[] back to back, then drop valid (no edge consumed).
    task automatic send(input int n, input logic [15:0] len);
        for (int i = 0; i < n; i++) begin
            udp_rec_data_valid  = 1'b1;
            udp_rec_rdata       = pkt[i];
            udp_rec_data_length = len;
            step();
        end
        udp_rec_data_valid = 1'b0;
        udp_rec_rdata      = 8'h00;
    endtask

    task automatic chk_frame(input string tag, input logic [63:0] data, input logic [15:0] len,
                             input logic trunc, input logic len_err);
        chk({tag, "_valid"}, 64'(rx_frame_valid), 64'd1);
        chk({tag, "_data"}, rx_frame_data, data);
        chk({tag, "_len"}, 64'(rx_frame_length), 64'(len));
        chk({tag, "_trunc"}, 64'(rx_frame_trunc), 64'(trunc));
        chk({tag, "_lenerr"}, 64'(rx_frame_len_err), 64'(len_err));
    endtask

    initial begin
        checks              = 0;
        errors              = 0;
        rstn                = 1'b0;
        udp_rec_data_valid  = 1'b0;
        udp_rec_rdata       = 8'h00;
        udp_rec_data_length = 16'd0;
        rx_frame_ready      = 1'b0;
        for (int i = 0; i < 16; i++) pkt[i] = 8'h00;

        #12;
        chk("rst_valid", 64'(rx_frame_valid), 64'd0);
        chk("rst_data", rx_frame_data, 64'd0);
        chk("rst_len", 64'(rx_frame_length), 64'd0);
        chk("rst_drop", 64'(rx_drop_cnt), 64'd0);
        rstn = 1'b1;
        step();
        step();

        // Zero-length: valid never raised, no frame appears.
        step();
        chk("idle_valid", 64'(rx_frame_valid), 64'd0);

        // Test 1: 4 bytes, exact length, consumer ready.
        rx_frame_ready = 1'b1;
        pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33; pkt[3] = 8'h44;
        send(4, 16'd4);
        chk("t1_lat", 64'(rx_frame_valid), 64'd0);
        step();
        chk_frame("t1", 64'h11223344_00000000, 16'd4, 1'b0, 1'b0);
        step();
        chk("t1_clr", 64'(rx_frame_valid), 64'd0);

        // Test 2: 10 bytes into 8-byte register -> truncated.
        for (int i = 0; i < 10; i++) pkt[i] = 8'(i + 1);
        send(10, 16'd10);
        step();
        chk_frame("t2", 64'h01020304_05060708, 16'd8, 1'b1, 1'b0);
        step();
        chk("t2_clr", 64'(rx_frame_valid), 64'd0);

        // Test 3: 3 bytes with a length field of 5.
        pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h03;
        send(3, 16'd5);
        step();
        chk_frame("t3", 64'h01020300_00000000, 16'd3, 1'b0, 1'b1);
        step();
        chk("t3_clr", 64'(rx_frame_valid), 64'd0);

        // Test 4: frame A held with ready=0, packet B dropped.
        rx_frame_ready = 1'b0;
        pkt[0] = 8'hAA; pkt[1] = 8'hBB;
        send(2, 16'd2);
        step();
        chk_frame("t4a", 64'hAABB0000_00000000, 16'd2, 1'b0, 1'b0);
        pkt[0] = 8'hC1; pkt[1] = 8'hC2; pkt[2] = 8'hC3;
        send(3, 16'd3);
        chk("t4_mid_drop", 64'(rx_drop_cnt), 64'd0);
        chk("t4_mid_data", rx_frame_data, 64'hAABB0000_00000000);
        step();
        chk("t4_drop", 64'(rx_drop_cnt), 64'd1);
        chk_frame("t4held", 64'hAABB0000_00000000, 16'd2, 1'b0, 1'b0);
        rx_frame_ready = 1'b1;
        step();
        chk("t4_clr", 64'(rx_frame_valid), 64'd0);

        // Test 5: accept coincides with first byte of B -> B collected.
        rx_frame_ready = 1'b0;
        pkt[0] = 8'hAA; pkt[1] = 8'hBB;
        send(2, 16'd2);
        step();
        chk("t5a_valid", 64'(rx_frame_valid), 64'd1);
        rx_frame_ready      = 1'b1;
        udp_rec_data_valid  = 1'b1;
        udp_rec_rdata       = 8'hD1;
        udp_rec_data_length = 16'd3;
        step();
        rx_frame_ready = 1'b0;
        chk("t5_acc", 64'(rx_frame_valid), 64'd0);
        pkt[0] = 8'hD2; pkt[1] = 8'hD3;
        send(2, 16'd3);
        step();
        chk_frame("t5b", 64'hD1D2D300_00000000, 16'd3, 1'b0, 1'b0);
        chk("t5_drop", 64'(rx_drop_cnt), 64'd1);
        rx_frame_ready = 1'b1;
        step();
        chk("t5_clr", 64'(rx_frame_valid), 64'd0);

        // Test 6: asynchronous reset in the middle of a packet.
        pkt[0] = 8'h77; pkt[1] = 8'h88; pkt[2] = 8'h99;
        udp_rec_data_valid  = 1'b1;
        udp_rec_rdata       = 8'h77;
        udp_rec_data_length = 16'd3;
        step();
        udp_rec_rdata = 8'h88;
        step();
        #2;
        rstn               = 1'b0;
        udp_rec_data_valid = 1'b0;
        #1;
        chk("t6_valid", 64'(rx_frame_valid), 64'd0);
        chk("t6_data", rx_frame_data, 64'd0);
        chk("t6_drop", 64'(rx_drop_cnt), 64'd0);
        chk("t6_flags", {62'd0, rx_frame_trunc, rx_frame_len_err}, 64'd0);
        #3;
        rstn = 1'b1;
        step();
        step();
        pkt[0] = 8'h5A; pkt[1] = 8'hA5;
        send(2, 16'd2);
        step();
        chk_frame("t6post", 64'h5AA50000_00000000, 16'd2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_rx_frame_packer.md
Name: udp_rx_frame_packer

Overview:
- Receive-side counterpart of the wide-word UDP send interface.
- Collects the byte-serial UDP payload stream (udp_rec_data_valid / udp_rec_rdata / udp_rec_data_length) from eth_udp_test into one UDP_LENGTH*8-bit frame register.
- Presents the frame to the user logic with a valid/ready handshake.
- Sits in the rgmii_clk domain beside eth_udp_test. Frames that arrive while the previous frame is still unconsumed are dropped and counted.

Parameters:
UDP_LENGTH  960  frame register capacity in bytes (≥2)
CNT_W       16   width of byte counter and drop counter

Ports:
rgmii_clk            input   1               receive clock; all logic on rising edge
rstn                 input   1               asynchronous, active-low reset
udp_rec_data_valid   input   1               high for each payload byte; contiguous per packet, low ≥1 cycle between packets
udp_rec_rdata        input   8               payload byte
udp_rec_data_length  input   16              UDP payload length announced for the packet, stable while valid
rx_frame_valid       output  1               frame register holds a complete frame
rx_frame_ready       input   1               consumer accepts frame
rx_frame_data        output  UDP_LENGTH*8    first byte in [UDP_LENGTH*8-1 -: 8], then descending; unfilled bytes 0
rx_frame_length      output  CNT_W           bytes stored (≤UDP_LENGTH)
rx_frame_trunc       output  1               packet exceeded UDP_LENGTH; excess bytes discarded
rx_frame_len_err     output  1               received byte count ≠ sampled udp_rec_data_length
rx_drop_cnt          output  CNT_W           saturating count of dropped packets

Behaviour:
- Reset (rstn=0, async): all outputs, rx_frame_data, counters and state cleared to 0; state=IDLE.
- States:
  - IDLE: waiting for a packet.
  - COLLECT: writing bytes into the frame register.
  - DROP: discarding a packet.
- accept = rx_frame_valid & rx_frame_ready. On an accept edge rx_frame_valid clears next cycle.
- Packet start = udp_rec_data_valid=1 in IDLE.
  - If rx_frame_valid=0 or accept in the same cycle: go to COLLECT.
    - Clear frame register, write byte to slot 0, byte count=1.
    - Sample udp_rec_data_length; clear trunc/len_err.
  - Otherwise: go to DROP.
- COLLECT, each valid cycle:
  - If count < UDP_LENGTH, write byte to slot count.
  - Otherwise set trunc.
  - Increment count, saturating at 2^CNT_W-1.
- COLLECT, first cycle valid=0:
  - Next edge: state=IDLE, rx_frame_valid=1.
  - rx_frame_length = min(count, UDP_LENGTH).
  - len_err = (count ≠ sampled length).
  - Latency: valid rises 1 cycle after the last byte cycle.
- DROP:
  - Ignore bytes; the held frame and its outputs stay untouched.
  - A handshake in DROP is honoured: rx_frame_valid clears.
  - On valid=0, return to IDLE and increment rx_drop_cnt (saturating at all-ones).
- Packet start while in DROP's final cycle cannot happen (≥1 idle cycle guaranteed).
- If an accept and a packet start occur in the same cycle, the new packet is collected and none is dropped.
- rx_frame_data/length/flags are stable whenever rx_frame_valid=1.
- Contents during COLLECT are undefined to the consumer.
- Zero-length packet (valid never high): no frame produced.
- Reset mid-packet: returns to IDLE. Remaining bytes of that packet are treated as a new packet only if valid is high at the first post-reset edge; the bench must not depend on that case.

Test Plan (UDP_LENGTH=8):
- Send 4 bytes 11,22,33,44, length=4, ready=1 → one cycle after last byte, valid=1; data=64'h11223344_00000000; length=4; trunc=0; len_err=0; valid clears next cycle.
- Send 10 bytes 01..0A, length=10 → data=64'h0102030405060708; length=8; trunc=1; len_err=0.
- Send 3 bytes, length field=5 → length=3; len_err=1.
- Hold ready=0; send packet A (2 bytes AA,BB), then packet B (3 bytes) → valid stays 1 with A data throughout; rx_drop_cnt=1 after B ends; raise ready → valid clears.
- Assert ready in the same cycle as the first byte of packet B while A is held → A consumed, B collected, rx_drop_cnt unchanged, valid=1 with B data after B ends.
- Pulse rstn=0 mid-COLLECT asynchronously → all outputs 0 immediately; next clean 2-byte packet produces a correct frame.
